pwm_peripheral: RTL and testbench

Consumes the enable, PWM-mode and duty-cycle registers written over SPI and drives 16 output pins. Each pin is forced low, forced high, or driven by a shared 8-bit PWM waveform, according to its enable and PWM-mode bits. The duty value is shadowed at period boundaries, so a register write never produces a truncated or glitched pulse. The block sits directly downstream of the SPI register block and directly upstream of the chip output pins.

---
 rtl/pwm_if.sv | 25 ++
 rtl/pwm_peripheral.sv | 83 ++++++++
 tb/tb_pwm_peripheral.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_if.sv
// Register-side and pin-side signals of the PWM output block.
interface pwm_if;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] out_7_0;
  logic [7:0] out_15_8;
  logic       period_start;

  // Register block side: drives configuration, observes pins.
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    input  out_7_0, out_15_8, period_start
  );

  // Peripheral side: consumes configuration, drives pins.
  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    output out_7_0, out_15_8, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-channel output driver: each pin is forced low, forced high, or follows a
// shared 8-bit PWM waveform whose duty is shadowed at period boundaries.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic clk,
  input  logic rst_n,
  pwm_if.slave bus
);

  localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
  localparam logic [7:0] CNT_LAST = 8'd254;
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic [7:0]         duty_sh_q, duty_sh_d;
  logic               run_q, run_d;
  logic               period_start_q, period_start_d;
  logic [15:0]        out_q, out_d;

  logic        tick;
  logic        wrap;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  // Next-state: counters hold for one clk after reset so the first period
  // starts with a period_start pulse like every later period.
  always_comb begin
    presc_cnt_d    = presc_cnt_q;
    pwm_cnt_d      = pwm_cnt_q;
    duty_sh_d      = duty_sh_q;
    run_d          = 1'b1;
    period_start_d = 1'b0;
    out_d          = 16'h0000;

    tick    = run_q && (presc_cnt_q == PRESC_MAX);
    wrap    = tick && (pwm_cnt_q == CNT_LAST);
    pwm_sig = (duty_sh_q == DUTY_FULL) || (pwm_cnt_q < duty_sh_q);

    if (run_q) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
    end
    if (tick) begin
      pwm_cnt_d = wrap ? 8'd0 : pwm_cnt_q + 8'd1;
    end
    if (wrap) begin
      duty_sh_d = bus.pwm_duty_cycle;
    end

    period_start_d = !run_q || wrap;
    out_d          = en_out & (~en_pwm | {16{pwm_sig}});
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_q    <= '0;
      pwm_cnt_q      <= 8'd0;
      duty_sh_q      <= 8'd0;
      run_q          <= 1'b0;
      period_start_q <= 1'b0;
      out_q          <= 16'h0000;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_sh_q      <= duty_sh_d;
      run_q          <= run_d;
      period_start_q <= period_start_d;
      out_q          <= out_d;
    end
  end

  assign bus.out_7_0      = out_q[7:0];
  assign bus.out_15_8     = out_q[15:8];
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench: a PRESCALE=1 instance for waveform/boundary checks and a
// PRESCALE=4 instance for prescaler timing.
module tb_pwm_peripheral;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_if if_a ();
  pwm_if if_b ();

  pwm_peripheral #(.PRESCALE(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  pwm_peripheral #(.PRESCALE(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs(input int sel);
    return (sel == 0) ? {if_a.out_15_8, if_a.out_7_0} : {if_b.out_15_8, if_b.out_7_0};
  endfunction

  function automatic logic pstart(input int sel);
    return (sel == 0) ? if_a.period_start : if_b.period_start;
  endfunction

  task automatic set_duty(input int sel, input logic [7:0] d);
    if (sel == 0) if_a.pwm_duty_cycle = d;
    else          if_b.pwm_duty_cycle = d;
  endtask

  task automatic set_cfg(input int sel, input logic [15:0] eo, input logic [15:0] ep,
                         input logic [7:0] d);
    if (sel == 0) begin
      {if_a.en_reg_out_15_8, if_a.en_reg_out_7_0} = eo;
      {if_a.en_reg_pwm_15_8, if_a.en_reg_pwm_7_0} = ep;
    end else begin
      {if_b.en_reg_out_15_8, if_b.en_reg_out_7_0} = eo;
      {if_b.en_reg_pwm_15_8, if_b.en_reg_pwm_7_0} = ep;
    end
    set_duty(sel, d);
  endtask

  // Called at a negedge where period_start is high; runs to the next pulse.
  task automatic measure(input int sel, input int wr_at, input logic [7:0] wr_val,
                         output int len, output int high, output int first_hi,
                         output int bad);
    len = 0; high = 0; first_hi = -1; bad = 0;
    do begin
      if (len == wr_at) set_duty(sel, wr_val);
      if (outs(sel) == 16'hFFFF) begin
        high++;
        if (first_hi < 0) first_hi = len;
      end else if (outs(sel) != 16'h0000) begin
        bad++;
      end
      len++;
      @(negedge clk);
    end while (!pstart(sel) && len < 5000);
  endtask

  task automatic wait_ps(input int sel, input string tag);
    int n;
    n = 0;
    while (!pstart(sel) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(pstart(sel)), 32'd1);
  endtask

  int len, high, fh, bad;

  initial begin
    set_cfg(0, 16'hFFFF, 16'hFFFF, 8'h80);
    set_cfg(1, 16'hFFFF, 16'hFFFF, 8'h40);
    repeat (3) @(negedge clk);
    check("rst_out_a", 32'(outs(0)), 32'h0);
    check("rst_ps_a", 32'(pstart(0)), 32'h0);
    check("rst_out_b", 32'(outs(1)), 32'h0);

    rst_n = 1'b1;
    @(negedge clk);
    check("ps_after_release", 32'(pstart(0)), 32'd1);

    // First period runs with the reset duty of 0.
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("p0_len", 32'(len), 32'd255);
    check("p0_high", 32'(high), 32'd0);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("d80_len", 32'(len), 32'd255);
    check("d80_high", 32'(high), 32'd128);
    check("d80_first", 32'(fh), 32'd1);
    check("d80_same", 32'(bad), 32'd0);

    // Duty 0x00.
    set_duty(0, 8'h00);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("d00_prev_high", 32'(high), 32'd128);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("d00_high", 32'(high), 32'd0);
    check("d00_same", 32'(bad), 32'd0);

    // Duty 0xFF: first window carries one low clk from the previous period.
    set_duty(0, 8'hFF);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("dff_prev_high", 32'(high), 32'd0);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("dff_first_high", 32'(high), 32'd254);
    for (int i = 0; i < 3; i++) begin
      measure(0, -1, 8'h00, len, high, fh, bad);
      check("dff_high", 32'(high), 32'd255);
    end

    // Duty 0x01: after the transition window, one high clk right after period_start.
    set_duty(0, 8'h01);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("d01_prev_high", 32'(high), 32'd255);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("d01_trans_high", 32'(high), 32'd2);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("d01_high", 32'(high), 32'd1);
    check("d01_first", 32'(fh), 32'd1);

    // Mid-period write at pwm_cnt == 50 only affects the next period.
    set_duty(0, 8'h80);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("mid_prev_high", 32'(high), 32'd1);
    measure(0, 50, 8'h20, len, high, fh, bad);
    check("mid_cur_high", 32'(high), 32'd128);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("mid_next_high", 32'(high), 32'd32);
    check("mid_next_len", 32'(len), 32'd255);

    // Mixed modes.
    set_cfg(0, 16'h00F0, 16'h0030, 8'h80);
    @(negedge clk);
    wait_ps(0, "mix_wait0");
    @(negedge clk);
    wait_ps(0, "mix_wait1");
    repeat (10) @(negedge clk);
    check("mix_hi", 32'(outs(0)), 32'h00F0);
    repeat (190) @(negedge clk);
    check("mix_lo", 32'(outs(0)), 32'h00C0);
    wait_ps(0, "mix_wait2");
    repeat (10) @(negedge clk);
    check("mix_hi2", 32'(outs(0)), 32'h00F0);
    set_cfg(0, 16'h00E0, 16'h0030, 8'h80);
    check("mix_clr_same_clk", 32'(outs(0)), 32'h00F0);
    @(negedge clk);
    check("mix_clr", 32'(outs(0)), 32'h00E0);

    // Reset while outputs are high.
    set_cfg(0, 16'hFFFF, 16'hFFFF, 8'h80);
    @(negedge clk);
    wait_ps(0, "rst_wait");
    repeat (5) @(negedge clk);
    check("pre_rst_out", 32'(outs(0)), 32'hFFFF);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(outs(0)), 32'h0);
    check("async_rst_ps", 32'(pstart(0)), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ps_after_rst2", 32'(pstart(0)), 32'd1);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("rst2_p0_high", 32'(high), 32'd0);
    check("rst2_p0_len", 32'(len), 32'd255);
    measure(0, -1, 8'h00, len, high, fh, bad);
    check("rst2_p1_high", 32'(high), 32'd128);

    // PRESCALE=4 instance, restarted by a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("b_ps_after_release", 32'(pstart(1)), 32'd1);
    measure(1, -1, 8'h00, len, high, fh, bad);
    check("b_p0_len", 32'(len), 32'd1020);
    check("b_p0_high", 32'(high), 32'd0);
    measure(1, -1, 8'h00, len, high, fh, bad);
    check("b_len", 32'(len), 32'd1020);
    check("b_high", 32'(high), 32'd256);
    check("b_first", 32'(fh), 32'd1);
    check("b_same", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
